// File: rtl/usb_tx_pkg.sv
// ----------------------------------------------------------------------------
// usb_tx_pkg
// Shared types and constants for the USB transmit buffer slice.
//   tx_packet_t   : packet type handed to the transmitter (0 = no packet)
//   txbuf_state_t : command sequencer states of usb_tx_buffer
//   TXBUF_DEPTH   : default number of payload FIFO entries
// ----------------------------------------------------------------------------
package usb_tx_pkg;

    localparam int TXBUF_DEPTH  = 64;
    localparam int TXBUF_ADDR_W = $clog2(TXBUF_DEPTH);

    typedef enum logic [1:0] {
        PKT_NONE = 2'd0,
        PKT_DATA = 2'd1,
        PKT_ACK  = 2'd2,
        PKT_NAK  = 2'd3
    } tx_packet_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } txbuf_state_t;

    // Encoding 0 is reserved for "no packet" and can never be commanded.
    function automatic logic isLegalCmd(input logic [1:0] cmd);
        return (cmd != PKT_NONE);
    endfunction

endpackage

// File: rtl/tx_fifo_mem.sv
// ----------------------------------------------------------------------------
// tx_fifo_mem
// DEPTH x 8 payload storage for the transmit FIFO. Synchronous write port,
// asynchronous (fall-through) read port. The data array has no reset; the
// pointer and flag logic in the parent decides which entries are valid.
//   clk     : system clock, rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write byte
//   raddr_i : read address
//   rdata_o : byte stored at raddr_i
// ----------------------------------------------------------------------------
module tx_fifo_mem #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usb_tx_buffer.sv
// ----------------------------------------------------------------------------
// usb_tx_buffer
// Feeds the USB transmitter. The host loads payload bytes into a FIFO and
// then issues a one-cycle send command. The block announces the packet type
// for one cycle, holds the payload size snapshot while the packet is in
// flight, serves one byte per get_tx_packet, and waits for tx_done before
// accepting another command.
//   clk, rst            : clock (rising edge), async active-high reset
//   wr_en, wr_data      : host byte write
//   start_cmd,cmd_packet: send request (1=DATA, 2=ACK, 3=NAK, 0 illegal)
//   flush               : clear FIFO and sticky error (only while idle)
//   tx_packet           : packet type to transmitter, valid one cycle
//   tx_packet_data_size : payload byte count of the packet in flight
//   tx_packet_data      : head-of-FIFO byte, 0 when empty
//   get_tx_packet       : transmitter pop strobe
//   tx_done             : transmitter completion pulse
//   busy, send_done     : sequencer status
//   occupancy,full,empty: FIFO status
//   error               : sticky overflow / underflow / illegal command
// ----------------------------------------------------------------------------
module usb_tx_buffer
    import usb_tx_pkg::*;
#(
    parameter int DEPTH  = TXBUF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       start_cmd,
    input  logic [1:0] cmd_packet,
    input  logic       flush,
    output logic [1:0] tx_packet,
    output logic [6:0] tx_packet_data_size,
    output logic [7:0] tx_packet_data,
    input  logic       get_tx_packet,
    input  logic       tx_done,
    output logic       busy,
    output logic       send_done,
    output logic [6:0] occupancy,
    output logic       full,
    output logic       empty,
    output logic       error
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] occ;
    txbuf_state_t     state_q, state_d;
    tx_packet_t       pktType_q, pktType_d;
    logic [6:0]       pktSize_q, pktSize_d;
    logic             error_q, error_d;

    logic [7:0] memRdata;
    logic       fifoEmpty;
    logic       fifoFull;
    logic       flushTaken;
    logic       doPop;
    logic       doPush;
    logic       overflow;
    logic       underflow;
    logic       illegalCmd;

    assign occ       = wrPtr_q - rdPtr_q;
    assign fifoEmpty = (occ == '0);
    assign fifoFull  = (occ == PTR_W'(DEPTH));

    // A flush only counts while idle, and it overrides any same-cycle
    // write or pop so the FIFO comes out truly empty.
    assign flushTaken = flush && (state_q == IDLE);
    assign doPop      = get_tx_packet && !fifoEmpty && !flushTaken;
    // A simultaneous pop frees the slot, so a write into a full FIFO is fine.
    assign doPush     = wr_en && (!fifoFull || doPop) && !flushTaken;
    assign overflow   = wr_en && fifoFull && !doPop && !flushTaken;
    // Popping an empty FIFO is an error even if a byte is written in the
    // same cycle: there is no write-to-read bypass.
    assign underflow  = get_tx_packet && fifoEmpty;

    tx_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (doPush),
        .waddr_i (wrPtr_q[ADDR_W-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rdPtr_q[ADDR_W-1:0]),
        .rdata_o (memRdata)
    );

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (flushTaken) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
        end
    end

    // Command sequencer. The DATA size snapshot uses the occupancy before
    // this cycle's write, so a byte written alongside start_cmd is not part
    // of the packet. The size register is cleared on the way back to IDLE.
    always_comb begin
        state_d    = state_q;
        pktType_d  = pktType_q;
        pktSize_d  = pktSize_q;
        illegalCmd = 1'b0;
        send_done  = 1'b0;
        tx_packet  = PKT_NONE;
        unique case (state_q)
            IDLE: begin
                if (start_cmd) begin
                    if (isLegalCmd(cmd_packet)) begin
                        pktType_d = tx_packet_t'(cmd_packet);
                        pktSize_d = (cmd_packet == PKT_DATA) ? 7'(occ) : 7'd0;
                        state_d   = ISSUE;
                    end else begin
                        illegalCmd = 1'b1;
                    end
                end
            end
            ISSUE: begin
                tx_packet = pktType_q;
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    send_done = 1'b1;
                    pktSize_d = 7'd0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                pktSize_d = 7'd0;
            end
        endcase
    end

    // Sticky error: a flush clears it and takes precedence over new events.
    always_comb begin
        error_d = error_q;
        if (flushTaken) begin
            error_d = 1'b0;
        end else if (overflow || underflow || illegalCmd) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            state_q   <= IDLE;
            pktType_q <= PKT_NONE;
            pktSize_q <= 7'd0;
            error_q   <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            state_q   <= state_d;
            pktType_q <= pktType_d;
            pktSize_q <= pktSize_d;
            error_q   <= error_d;
        end
    end

    assign busy                = (state_q != IDLE);
    assign occupancy           = 7'(occ);
    assign full                = fifoFull;
    assign empty               = fifoEmpty;
    assign error               = error_q;
    assign tx_packet_data      = fifoEmpty ? 8'h00 : memRdata;
    assign tx_packet_data_size = pktSize_q;

endmodule

// File: tb/tb_usb_tx_buffer.sv
// ----------------------------------------------------------------------------
// tb_usb_tx_buffer
// Directed bench for usb_tx_buffer. Written bytes go into a scoreboard
// queue and are popped and compared as the transmitter side pulls them.
// ----------------------------------------------------------------------------
module tb_usb_tx_buffer;
    import usb_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       start_cmd;
    logic [1:0] cmd_packet;
    logic       flush;
    logic [1:0] tx_packet;
    logic [6:0] tx_packet_data_size;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet;
    logic       tx_done;
    logic       busy;
    logic       send_done;
    logic [6:0] occupancy;
    logic       full;
    logic       empty;
    logic       error;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] sbq[$];

    usb_tx_buffer dut (
        .clk                 (clk),
        .rst                 (rst),
        .wr_en               (wr_en),
        .wr_data             (wr_data),
        .start_cmd           (start_cmd),
        .cmd_packet          (cmd_packet),
        .flush               (flush),
        .tx_packet           (tx_packet),
        .tx_packet_data_size (tx_packet_data_size),
        .tx_packet_data      (tx_packet_data),
        .get_tx_packet       (get_tx_packet),
        .tx_done             (tx_done),
        .busy                (busy),
        .send_done           (send_done),
        .occupancy           (occupancy),
        .full                (full),
        .empty               (empty),
        .error               (error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic s,
                                 input logic [1:0] c, input logic g, input logic td,
                                 input logic f);
        wr_en         = w;
        wr_data       = d;
        start_cmd     = s;
        cmd_packet    = c;
        get_tx_packet = g;
        tx_done       = td;
        flush         = f;
    endtask

    task automatic clearInputs();
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock; outputs are then sampled 2 time units past the edge.
    task automatic step();
        @(posedge clk);
        #1;
        clearInputs();
        #1;
    endtask

    task automatic writeByte(input logic [7:0] b);
        applyStimulus(1'b1, b, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        sbq.push_back(b);
        step();
    endtask

    task automatic popByte(input string tag);
        logic [7:0] exp;
        if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: scoreboard empty, no expected byte", tag);
        end else begin
            exp = sbq.pop_front();
            applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
            #1;
            checkOutput(tag, 32'(tx_packet_data), 32'(exp));
            step();
        end
    endtask

    // Issue a command and follow it through ISSUE into WAIT_DONE.
    task automatic sendPacket(input logic [1:0] cmd, input logic [6:0] expSize, input string tag);
        applyStimulus(1'b0, 8'h00, 1'b1, cmd, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput({tag, " issue tx_packet"}, 32'(tx_packet), 32'(cmd));
        checkOutput({tag, " issue size"}, 32'(tx_packet_data_size), 32'(expSize));
        checkOutput({tag, " issue busy"}, 32'(busy), 32'd1);
        step();
        checkOutput({tag, " wait tx_packet"}, 32'(tx_packet), 32'd0);
        checkOutput({tag, " wait size"}, 32'(tx_packet_data_size), 32'(expSize));
        checkOutput({tag, " wait busy"}, 32'(busy), 32'd1);
    endtask

    task automatic finishPacket(input string tag);
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput({tag, " send_done pulse"}, 32'(send_done), 32'd1);
        step();
        checkOutput({tag, " send_done clear"}, 32'(send_done), 32'd0);
        checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " idle size"}, 32'(tx_packet_data_size), 32'd0);
    endtask

    initial begin
        logic [7:0] exp;

        // Reset values
        rst = 1'b1;
        clearInputs();
        #3;
        checkOutput("rst tx_packet", 32'(tx_packet), 32'd0);
        checkOutput("rst size", 32'(tx_packet_data_size), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst send_done", 32'(send_done), 32'd0);
        checkOutput("rst error", 32'(error), 32'd0);
        checkOutput("rst occupancy", 32'(occupancy), 32'd0);
        checkOutput("rst empty", 32'(empty), 32'd1);
        checkOutput("rst full", 32'(full), 32'd0);
        checkOutput("rst data", 32'(tx_packet_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // 1: four-byte DATA packet
        $display("[TB] DATA packet of 4 bytes");
        for (int i = 0; i < 4; i++) writeByte(8'hA1 + 8'(i));
        checkOutput("t1 occupancy", 32'(occupancy), 32'd4);
        sendPacket(PKT_DATA, 7'd4, "t1");
        for (int i = 0; i < 4; i++) popByte("t1 payload");
        finishPacket("t1");
        checkOutput("t1 empty", 32'(empty), 32'd1);
        checkOutput("t1 error", 32'(error), 32'd0);

        // 2: ACK and NAK on an empty FIFO
        $display("[TB] ACK and NAK packets");
        sendPacket(PKT_ACK, 7'd0, "t2 ack");
        checkOutput("t2 ack occupancy", 32'(occupancy), 32'd0);
        finishPacket("t2 ack");
        sendPacket(PKT_NAK, 7'd0, "t2 nak");
        finishPacket("t2 nak");
        checkOutput("t2 error", 32'(error), 32'd0);

        // 3: fill, overflow, flush, simultaneous write/pop while full
        $display("[TB] full / overflow / flush");
        for (int i = 0; i < 64; i++) writeByte(8'(i));
        checkOutput("t3 full", 32'(full), 32'd1);
        checkOutput("t3 occupancy 64", 32'(occupancy), 32'd64);
        checkOutput("t3 no error yet", 32'(error), 32'd0);
        applyStimulus(1'b1, 8'hEE, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("t3 overflow error", 32'(error), 32'd1);
        checkOutput("t3 overflow occupancy", 32'(occupancy), 32'd64);
        applyStimulus(1'b1, 8'h77, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        sbq.delete();
        checkOutput("t3 flush occupancy", 32'(occupancy), 32'd0);
        checkOutput("t3 flush error", 32'(error), 32'd0);
        checkOutput("t3 flush empty", 32'(empty), 32'd1);
        for (int i = 0; i < 64; i++) writeByte(8'(i + 100));
        exp = sbq.pop_front();
        applyStimulus(1'b1, 8'h5A, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("t3 full pop data", 32'(tx_packet_data), 32'(exp));
        sbq.push_back(8'h5A);
        step();
        checkOutput("t3 wr+pop occupancy", 32'(occupancy), 32'd64);
        checkOutput("t3 wr+pop full", 32'(full), 32'd1);
        checkOutput("t3 wr+pop error", 32'(error), 32'd0);
        while (sbq.size() > 0) popByte("t3 drain");
        checkOutput("t3 drained empty", 32'(empty), 32'd1);

        // 4: wrap-around with 40-byte packets
        $display("[TB] wrap-around rounds");
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 40; i++) writeByte(8'($urandom_range(0, 255)));
            sendPacket(PKT_DATA, 7'd40, "t4");
            for (int i = 0; i < 40; i++) popByte("t4 payload");
            finishPacket("t4");
        end
        checkOutput("t4 empty", 32'(empty), 32'd1);
        checkOutput("t4 error", 32'(error), 32'd0);

        // 5: underflow, no bypass, illegal command, start while busy
        $display("[TB] error cases");
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("t5 empty data", 32'(tx_packet_data), 32'd0);
        step();
        checkOutput("t5 underflow error", 32'(error), 32'd1);
        checkOutput("t5 underflow occupancy", 32'(occupancy), 32'd0);
        checkOutput("t5 underflow data", 32'(tx_packet_data), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("t5 flush clears error", 32'(error), 32'd0);
        applyStimulus(1'b1, 8'h3C, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        sbq.push_back(8'h3C);
        step();
        checkOutput("t5 no-bypass error", 32'(error), 32'd1);
        checkOutput("t5 no-bypass occupancy", 32'(occupancy), 32'd1);
        popByte("t5 no-bypass byte");
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("t5 illegal cmd error", 32'(error), 32'd1);
        checkOutput("t5 illegal cmd busy", 32'(busy), 32'd0);
        checkOutput("t5 illegal cmd tx_packet", 32'(tx_packet), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("t5 flush error", 32'(error), 32'd0);
        sendPacket(PKT_ACK, 7'd0, "t5 ack");
        applyStimulus(1'b0, 8'h00, 1'b1, PKT_DATA, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("t5 busy start busy", 32'(busy), 32'd1);
        checkOutput("t5 busy start tx_packet", 32'(tx_packet), 32'd0);
        checkOutput("t5 busy start error", 32'(error), 32'd0);
        finishPacket("t5 ack");
        step();
        checkOutput("t5 no queued cmd", 32'(busy), 32'd0);

        // 6: reset in WAIT_DONE with bytes queued
        $display("[TB] reset mid-packet");
        for (int i = 0; i < 10; i++) writeByte(8'hC0 + 8'(i));
        sendPacket(PKT_DATA, 7'd10, "t6");
        rst = 1'b1;
        #1;
        checkOutput("t6 rst busy", 32'(busy), 32'd0);
        checkOutput("t6 rst occupancy", 32'(occupancy), 32'd0);
        checkOutput("t6 rst empty", 32'(empty), 32'd1);
        checkOutput("t6 rst size", 32'(tx_packet_data_size), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("t6 rst send_done", 32'(send_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("t6 tx_done ignored", 32'(send_done), 32'd0);
        step();
        checkOutput("t6 idle busy", 32'(busy), 32'd0);
        checkOutput("t6 idle occupancy", 32'(occupancy), 32'd0);
        checkOutput("t6 idle error", 32'(error), 32'd0);
        sbq.delete();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
